// File: rtl/rsp_reader.sv
// rtl/rsp_reader.sv - read-side sequencer that streams PAR_READ-word groups
// from the scratchpad's combinational read port onto a valid/ready output.
module rsp_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 3,
  parameter int PAR_READ    = 1,
  parameter int COUNT_WIDTH = ADDR_WIDTH + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [COUNT_WIDTH-1:0]         count,
  output logic [ADDR_WIDTH-1:0]          sp_raddr,
  input  logic [PAR_READ*DATA_WIDTH-1:0] sp_rdata,
  output logic [PAR_READ*DATA_WIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  localparam logic [ADDR_WIDTH-1:0]  ADDR_STEP = ADDR_WIDTH'(PAR_READ);
  localparam logic [COUNT_WIDTH-1:0] ONE_BEAT  = COUNT_WIDTH'(1);

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   load;

  assign sp_raddr = addr;

  // The output register can take a new beat when empty or being drained this edge.
  assign load = (state == S_READ) && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      if (load) begin
        out_data  <= sp_rdata;
        out_valid <= 1'b1;
        addr      <= addr + ADDR_STEP;
        remaining <= remaining - ONE_BEAT;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            if (count != '0) begin
              addr      <= base_addr;
              remaining <= count;
              busy      <= 1'b1;
              state     <= S_READ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (load && remaining == ONE_BEAT) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_valid && out_ready) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsp_reader.sv
// tb/tb_rsp_reader.sv - scoreboard bench driving a PAR_READ=1 and a PAR_READ=2
// instance in lockstep from one shared 8-word scratchpad model.
module tb_rsp_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  base_addr;
  logic [3:0]  count;
  logic        out_ready;

  logic [2:0]  sp_raddr1, sp_raddr2;
  logic [15:0] sp_rdata1, out_data1;
  logic [31:0] sp_rdata2, out_data2;
  logic        out_valid1, out_valid2, busy1, busy2, done1, done2;

  logic [15:0] mem [8];

  typedef struct {
    logic [15:0] d1;
    logic [31:0] d2;
    bit          last;
  } beat_t;

  beat_t q[$];
  bit    fresh    = 1'b0;
  bit    exp_done = 1'b0;
  bit    chk_en   = 1'b0;
  int    n_cmp    = 0;
  int    n_err    = 0;

  always #5 clk = ~clk;

  rsp_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .PAR_READ(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .sp_raddr(sp_raddr1), .sp_rdata(sp_rdata1), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1), .done(done1)
  );

  rsp_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .PAR_READ(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .sp_raddr(sp_raddr2), .sp_rdata(sp_rdata2), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2), .done(done2)
  );

  // Scratchpad read port: word j of a group comes from (raddr + j) mod 8.
  always_comb begin
    sp_rdata1 = mem[sp_raddr1];
    sp_rdata2 = '0;
    for (int j = 0; j < 2; j++) begin
      sp_rdata2[16*j +: 16] = mem[3'(int'(sp_raddr2) + j)];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares outputs against the queue head, then predicts the next edge.
  always @(negedge clk) begin
    bit nd;
    if (chk_en) begin
      chk("done1", done1, exp_done);
      chk("done2", done2, exp_done);
      chk("busy1", busy1, (q.size() != 0) && !fresh);
      chk("busy2", busy2, (q.size() != 0) && !fresh);
      if (out_valid1 || out_valid2) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got valid %0b/%0b expected none at %0t",
                   out_valid1, out_valid2, $time);
        end else begin
          chk("valid1", out_valid1, 1'b1);
          chk("valid2", out_valid2, 1'b1);
          chk("beat1", out_data1, q[0].d1);
          chk("beat2", out_data2, q[0].d2);
        end
      end
      nd = 1'b0;
      if (rst) begin
        q.delete();
      end else begin
        if (start && count == 4'd0 && q.size() == 0) nd = 1'b1;
        if (out_valid1 && out_ready && q.size() != 0) begin
          if (q[0].last) nd = 1'b1;
          void'(q.pop_front());
        end
      end
      exp_done = nd;
      fresh    = 1'b0;
    end
  end

  task automatic issue(input int b, input int c);
    beat_t e;
    int    a1, a2;
    @(posedge clk); #1;
    for (int k = 0; k < c; k++) begin
      a1     = (b + k) % 8;
      a2     = (b + 2 * k) % 8;
      e.d1   = mem[a1];
      e.d2   = {mem[(a2 + 1) % 8], mem[a2]};
      e.last = (k == c - 1);
      q.push_back(e);
    end
    if (c != 0) fresh = 1'b1;
    start     = 1'b1;
    base_addr = 3'(b);
    count     = 4'(c);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    while ((q.size() != 0 || exp_done) && n < 300) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got %0d beats pending expected 0", q.size());
      q.delete();
    end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
  endtask

  initial begin
    bit pat [5];
    int b, c;
    pat       = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0A00 + 16'(i);

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_valid1", out_valid1, 1'b0);
      chk("idle_valid2", out_valid2, 1'b0);
      chk("idle_raddr1", sp_raddr1, 3'd0);
      chk("idle_raddr2", sp_raddr2, 3'd0);
      chk("idle_data1", out_data1, 16'h0);
      chk("idle_data2", out_data2, 32'h0);
    end

    // Contiguous stream, PAR_READ=1 view: 0A02..0A05 back to back.
    issue(2, 4);
    @(negedge clk);
    chk("contig_first_gap", out_valid1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("contig_valid", out_valid1, 1'b1);
      chk("contig_data", out_data1, 16'h0A02 + 16'(k));
    end
    @(negedge clk);
    chk("contig_done", done1, 1'b1);
    chk("contig_drop", out_valid1, 1'b0);
    wait_idle(1'b0);

    // Wrap with PAR_READ=2 from address 6.
    rand_mem();
    issue(6, 2);
    @(negedge clk);
    chk("wrap_raddr0", sp_raddr2, 3'd6);
    @(negedge clk);
    chk("wrap_raddr1", sp_raddr2, 3'd0);
    wait_idle(1'b0);

    // Back-pressure pattern.
    rand_mem();
    issue(1, 3);
    for (int k = 0; k < 5; k++) begin
      out_ready = pat[k];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle(1'b0);

    // Zero-count request.
    issue(5, 0);
    @(negedge clk);
    chk("zero_busy", busy1, 1'b0);
    chk("zero_valid", out_valid1, 1'b0);
    wait_idle(1'b0);

    // Start pulsed mid-request is ignored.
    rand_mem();
    issue(3, 5);
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 3'd0; count = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(1'b1);

    // Reset after two of five beats accepted.
    rand_mem();
    issue(0, 5);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid1, 1'b0);
    chk("rst_done", done1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rand_mem();
    issue(4, 3);
    wait_idle(1'b0);

    // Randomized requests, including counts beyond the depth.
    for (int it = 0; it < 30; it++) begin
      rand_mem();
      b = $urandom_range(0, 7);
      c = $urandom_range(0, 12);
      issue(b, c);
      if (c > 2 && $urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        start = 1'b1; base_addr = 3'($urandom); count = 4'($urandom_range(1, 15));
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_idle(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish by 500000");
    $fatal(1);
  end

endmodule

// File: doc/rsp_reader.md
# rsp_reader

Read-side sequencer for the parallel scratchpad. It takes a base address and a beat count, then walks the scratchpad read port in steps of `PAR_READ` words. Each fetched `PAR_READ`-word group is registered and presented on a valid/ready output stream. The block sits between the scratchpad's combinational read port and any downstream consumer, such as a PE input stage or a bus adapter, and it produces back-to-back beats under full throughput.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of one scratchpad word
- `ADDR_WIDTH`, 3, scratchpad address width; depth is 2^`ADDR_WIDTH`
- `PAR_READ`, 1, words returned per scratchpad read; also the address step per beat
- `COUNT_WIDTH`, `ADDR_WIDTH`+1, width of the beat-count input

Ports:
- `clk`, in, 1, single clock, rising edge
- `rst`, in, 1, reset; synchronous, active-high
- `start`, in, 1, one-cycle request; sampled only in IDLE
- `base_addr`, in, `ADDR_WIDTH`, first read address; sampled with `start`
- `count`, in, `COUNT_WIDTH`, number of beats to read; sampled with `start`
- `sp_raddr`, out, `ADDR_WIDTH`, read address to the scratchpad
- `sp_rdata`, in, `PAR_READ`*`DATA_WIDTH`, combinational scratchpad read data for `sp_raddr`
- `out_data`, out, `PAR_READ`*`DATA_WIDTH`, registered beat; word j is at bits [`DATA_WIDTH`*(j+1)-1 -: `DATA_WIDTH`]
- `out_valid`, out, 1, `out_data` holds a beat
- `out_ready`, in, 1, consumer accepts the beat when both valid and ready are high at a rising edge
- `busy`, out, 1, high in READ and DRAIN
- `done`, out, 1, one-cycle pulse when a request completes

## Operation
- State register holds one of IDLE, READ, DRAIN.
- Internal registers:
  - `addr` (`ADDR_WIDTH` bits)
  - `remaining` (`COUNT_WIDTH` bits)
- `sp_raddr` = `addr` at all times.
- IDLE:
  - `start`=1 and `count`≠0: `addr`←`base_addr`, `remaining`←`count`, go to READ.
  - `start`=1 and `count`=0: `done` pulses the next cycle, state stays IDLE, no beats are issued.
- READ:
  - A load happens when (`out_valid`=0 or `out_ready`=1).
  - On a load: `out_data`←`sp_rdata`, `out_valid`←1, `addr`←`addr`+`PAR_READ` mod 2^`ADDR_WIDTH`, `remaining`←`remaining`−1.
  - On the load where `remaining`=1: go to DRAIN.
- Without a load, when `out_valid`=1 and `out_ready`=1: `out_valid`←0. This occurs only in IDLE and DRAIN.
- DRAIN: when the last beat is accepted (`out_valid`&`out_ready`), clear `out_valid`, pulse `done` the same cycle as the clear edge, and go to IDLE.
- `start` in READ or DRAIN is ignored, with no queuing.
- Address wrap: `addr` wraps modulo depth. Words within a beat wrap inside the scratchpad, because its own `raddr`+j truncates to `ADDR_WIDTH`.
- `out_data` holds its value while `out_valid`=1 and `out_ready`=0. It also holds its last value after `out_valid` drops.
- The data snapshot is taken at the load edge. Scratchpad writes to an address after its load are not reflected. A write at the same edge as the load is not reflected either, because data is sampled from pre-edge memory.
- `count` > 2^`ADDR_WIDTH`/`PAR_READ` is legal and re-reads wrapped addresses.

## Timing
- Reset (`rst`=1 at an edge): state IDLE, `addr`=0 (so `sp_raddr`=0), `remaining`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0.
- Reset mid-request aborts immediately. No `done` pulse is produced and any pending beat is dropped.
- Latency:
  - `start` sampled at edge 0: READ from edge 0, with `sp_raddr`=`base_addr` in cycle 1.
  - First beat valid after edge 1.
- Throughput: with `out_ready` held high, one beat per cycle. N beats occupy edges 1..N.
- Completion: last beat accepted at edge N+1, `done`=1 for cycle N+1→N+2, back in IDLE.
- Back-pressure: any stall holds `addr`, `remaining` and `out_data`. There are no bubbles once `out_ready` returns high.
- `busy` is high from the edge that samples `start` (with `count`≠0) until the edge that returns to IDLE.
- `done` is never high in the same cycle as `busy`.

## Test plan
- Reset, then idle: all outputs 0, `sp_raddr`=0, and `start`=0 held for 10 cycles keeps `out_valid`=0.
- Contiguous stream:
  - Setup: `PAR_READ`=1, memory[i]=16'h0A00+i, `base_addr`=2, `count`=4, `out_ready`=1.
  - Required: beats 0A02, 0A03, 0A04, 0A05 on 4 consecutive cycles, then one `done` pulse.
- Wrap:
  - Setup: `PAR_READ`=2, depth 8, `base_addr`=6, `count`=2.
  - Required: beat0 = {mem[7],mem[6]}, beat1 = {mem[1],mem[0]}, and `sp_raddr` sequence 6, 0.
- Back-pressure:
  - Setup: `count`=3, `out_ready` toggling 1,0,0,1,1.
  - Required: each beat is held stable while stalled, there is no duplicate or skipped beat, and `done` follows the third acceptance.
- Corner requests:
  - `count`=0: `done` pulses next cycle, `busy` stays 0, no `out_valid`.
  - `start` pulsed during READ: ignored; the original request completes with its count.
- Reset mid-stream: `rst` asserted after 2 of 5 beats. Required: `out_valid`=0 next cycle, no `done`, and a fresh request afterwards streams correctly.
